// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB plus a PHT of saturating counters,
// optionally gshare-indexed by a non-speculative global history register.
module branch_predictor #(
   parameter int WIDTH     = 32,
   parameter int ENTRIES   = 16,
   parameter int CTR_BITS  = 2,
   parameter int GHR_BITS  = 0,
   parameter int STAT_BITS = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     PCF,
   input  logic                 updateE,
   input  logic                 isJumpE,
   input  logic [WIDTH-1:0]     PCE,
   input  logic                 takenE,
   input  logic [WIDTH-1:0]     targetE,
   input  logic                 predTakenE,
   input  logic [WIDTH-1:0]     predTargetE,
   output logic [WIDTH-1:0]     PCBPU,
   output logic                 PCBPUSrc,
   output logic                 predTakenF,
   output logic                 flushBranch,
   output logic [STAT_BITS-1:0] branchCount,
   output logic [STAT_BITS-1:0] mispredCount
);
   localparam int IDX  = $clog2(ENTRIES);
   localparam int TAGW = WIDTH - IDX - 2;
   localparam int GW   = (GHR_BITS > 0) ? GHR_BITS : 1;
   localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};
   localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1'b1) << (CTR_BITS - 1);
   localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_WT - CTR_BITS'(1'b1);

   logic [ENTRIES-1:0]   valid_q, valid_d, jump_q, jump_d;
   logic [TAGW-1:0]      tag_q [ENTRIES];
   logic [TAGW-1:0]      tag_d [ENTRIES];
   logic [WIDTH-1:0]     target_q [ENTRIES];
   logic [WIDTH-1:0]     target_d [ENTRIES];
   logic [CTR_BITS-1:0]  ctr_q [ENTRIES];
   logic [CTR_BITS-1:0]  ctr_d [ENTRIES];
   logic [GW-1:0]        ghr_q, ghr_d;
   logic [STAT_BITS-1:0] branch_count_q, branch_count_d;
   logic [STAT_BITS-1:0] mispred_count_q, mispred_count_d;

   logic [IDX-1:0]  ghr_idx_s, bi_f_s, pi_f_s, bi_e_s, pi_e_s;
   logic [TAGW-1:0] tag_f_s, tag_e_s;
   logic            hit_f_s, hit_e_s, pred_f_s, mis_s;
   logic            unused_s;

   // Table indexing and lookup for both the fetch and the execute PC.
   always_comb begin
      ghr_idx_s = '0;
      if (GHR_BITS > 0) begin
         ghr_idx_s[GW-1:0] = ghr_q;
      end else begin
         ghr_idx_s = '0;
      end
      bi_f_s   = PCF[IDX+1:2];
      tag_f_s  = PCF[WIDTH-1:IDX+2];
      pi_f_s   = bi_f_s ^ ghr_idx_s;
      bi_e_s   = PCE[IDX+1:2];
      tag_e_s  = PCE[WIDTH-1:IDX+2];
      pi_e_s   = bi_e_s ^ ghr_idx_s;
      hit_f_s  = valid_q[bi_f_s] && (tag_q[bi_f_s] == tag_f_s);
      hit_e_s  = valid_q[bi_e_s] && (tag_q[bi_e_s] == tag_e_s);
      pred_f_s = hit_f_s && (jump_q[bi_f_s] || ctr_q[pi_f_s][CTR_BITS-1]);
      mis_s    = updateE && ((takenE != predTakenE) ||
                             (takenE && (targetE != predTargetE)));
      unused_s = ^{PCF[1:0], PCE[1:0]};
   end

   // Next-PC mux: a resolved mispredict outranks the fetch-side prediction.
   always_comb begin
      PCBPU       = '0;
      PCBPUSrc    = 1'b0;
      predTakenF  = 1'b0;
      flushBranch = 1'b0;
      if (!rst) begin
         PCBPU       = '0;
         PCBPUSrc    = 1'b0;
         predTakenF  = 1'b0;
         flushBranch = 1'b0;
      end else if (mis_s) begin
         predTakenF  = pred_f_s;
         PCBPUSrc    = 1'b1;
         flushBranch = 1'b1;
         PCBPU       = takenE ? targetE : (PCE + WIDTH'(3'd4));
      end else begin
         predTakenF  = pred_f_s;
         PCBPUSrc    = pred_f_s;
         flushBranch = 1'b0;
         PCBPU       = target_q[bi_f_s];
      end
   end

   // Training: counters, BTB allocate/refresh, history and statistics.
   always_comb begin
      valid_d         = valid_q;
      jump_d          = jump_q;
      tag_d           = tag_q;
      target_d        = target_q;
      ctr_d           = ctr_q;
      ghr_d           = ghr_q;
      branch_count_d  = branch_count_q;
      mispred_count_d = mispred_count_q;
      if (updateE) begin
         if (isJumpE) begin
            ctr_d[pi_e_s] = CTR_MAX;
         end else if (takenE && !hit_e_s) begin
            ctr_d[pi_e_s] = CTR_WT;
         end else if (takenE) begin
            ctr_d[pi_e_s] = (ctr_q[pi_e_s] == CTR_MAX) ? CTR_MAX
                                                       : ctr_q[pi_e_s] + CTR_BITS'(1'b1);
         end else begin
            ctr_d[pi_e_s] = (ctr_q[pi_e_s] == '0) ? '0
                                                  : ctr_q[pi_e_s] - CTR_BITS'(1'b1);
         end
         if (takenE) begin
            valid_d[bi_e_s]  = 1'b1;
            jump_d[bi_e_s]   = isJumpE;
            tag_d[bi_e_s]    = tag_e_s;
            target_d[bi_e_s] = targetE;
         end else begin
            valid_d = valid_q;
         end
         // Only conditional outcomes carry pattern information.
         if (!isJumpE) begin
            ghr_d = (ghr_q << 1) | GW'(takenE);
         end else begin
            ghr_d = ghr_q;
         end
         branch_count_d = branch_count_q + STAT_BITS'(1'b1);
         if (mis_s) begin
            mispred_count_d = mispred_count_q + STAT_BITS'(1'b1);
         end else begin
            mispred_count_d = mispred_count_q;
         end
      end else begin
         ghr_d = ghr_q;
      end
   end

   // State registers; reset leaves every counter weakly not-taken.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q         <= '0;
         jump_q          <= '0;
         ghr_q           <= '0;
         branch_count_q  <= '0;
         mispred_count_q <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= CTR_WNT;
         end
      end else begin
         valid_q         <= valid_d;
         jump_q          <= jump_d;
         ghr_q           <= ghr_d;
         branch_count_q  <= branch_count_d;
         mispred_count_q <= mispred_count_d;
         tag_q           <= tag_d;
         target_q        <= target_d;
         ctr_q           <= ctr_d;
      end
   end

   assign branchCount  = branch_count_q;
   assign mispredCount = mispred_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: bimodal instance with a vector table plus
// hand sequences, and a gshare instance for the alternating-pattern comparison.
module tb_branch_predictor;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] PCF, PCE, targetE, predTargetE, g_predTargetE;
   logic         updateE, isJumpE, takenE, predTakenE, g_predTakenE;
   logic [W-1:0] PCBPU, g_PCBPU;
   logic         PCBPUSrc, predTakenF, flushBranch;
   logic         g_PCBPUSrc, g_predTakenF, g_flushBranch;
   logic [15:0]  branchCount, mispredCount;
   logic [2:0]   g_branchCount, g_mispredCount;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   branch_predictor dut (
      .clk(clk), .rst(rst), .PCF(PCF), .updateE(updateE), .isJumpE(isJumpE),
      .PCE(PCE), .takenE(takenE), .targetE(targetE), .predTakenE(predTakenE),
      .predTargetE(predTargetE), .PCBPU(PCBPU), .PCBPUSrc(PCBPUSrc),
      .predTakenF(predTakenF), .flushBranch(flushBranch),
      .branchCount(branchCount), .mispredCount(mispredCount)
   );

   branch_predictor #(.GHR_BITS(2), .STAT_BITS(3)) dut_g (
      .clk(clk), .rst(rst), .PCF(PCF), .updateE(updateE), .isJumpE(isJumpE),
      .PCE(PCE), .takenE(takenE), .targetE(targetE), .predTakenE(g_predTakenE),
      .predTargetE(g_predTargetE), .PCBPU(g_PCBPU), .PCBPUSrc(g_PCBPUSrc),
      .predTakenF(g_predTakenF), .flushBranch(g_flushBranch),
      .branchCount(g_branchCount), .mispredCount(g_mispredCount)
   );

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [W-1:0] pcf;
      logic         upd;
      logic [W-1:0] pce;
      logic         tkn;
      logic [W-1:0] tgt;
      logic         ptk;
      logic [W-1:0] ptg;
      logic         src;
      logic [W-1:0] pc;
      logic         ptf;
      logic         fl;
      int           bc;
      int           mc;
   } vec_t;

   vec_t vecs [17];

   initial begin
      logic         p;
      logic [W-1:0] t;
      logic         tk, exp_b, exp_g;
      int           bim_mis, g_mis, g_late;

      //          pcf      upd pce      tkn tgt      ptk ptg       src pc       ptf fl bc mc
      vecs[0]  = '{32'h40,  1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 0, 0};
      vecs[1]  = '{32'h40,  1'b1, 32'h40, 1'b1, 32'h20,  1'b0, 32'h0,   1'b1, 32'h20,  1'b0, 1'b1, 0, 0};
      vecs[2]  = '{32'h40,  1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h20,  1'b1, 1'b0, 1, 1};
      vecs[3]  = '{32'h40,  1'b1, 32'h40, 1'b0, 32'h20,  1'b1, 32'h20,  1'b1, 32'h44,  1'b1, 1'b1, 1, 1};
      vecs[4]  = '{32'h40,  1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h20,  1'b0, 1'b0, 2, 2};
      vecs[5]  = '{32'h40,  1'b1, 32'h40, 1'b0, 32'h20,  1'b0, 32'h20,  1'b0, 32'h20,  1'b0, 1'b0, 2, 2};
      vecs[6]  = '{32'h40,  1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h20,  1'b0, 1'b0, 3, 2};
      vecs[7]  = '{32'h48,  1'b1, 32'h40, 1'b1, 32'h30,  1'b1, 32'h20,  1'b1, 32'h30,  1'b0, 1'b1, 3, 2};
      vecs[8]  = '{32'h40,  1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h30,  1'b0, 1'b0, 4, 3};
      vecs[9]  = '{32'h40,  1'b1, 32'h40, 1'b1, 32'h30,  1'b1, 32'h30,  1'b0, 32'h30,  1'b0, 1'b0, 4, 3};
      vecs[10] = '{32'h40,  1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h30,  1'b1, 1'b0, 5, 3};
      vecs[11] = '{32'h440, 1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h30,  1'b0, 1'b0, 5, 3};
      vecs[12] = '{32'h84,  1'b1, 32'h84, 1'b0, 32'h100, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 5, 3};
      vecs[13] = '{32'h84,  1'b1, 32'h84, 1'b1, 32'h100, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 1'b1, 6, 3};
      vecs[14] = '{32'h84,  1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h100, 1'b1, 1'b0, 7, 4};
      vecs[15] = '{32'h84,  1'b1, 32'h84, 1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h88,  1'b1, 1'b1, 7, 4};
      vecs[16] = '{32'h84,  1'b0, 32'h0,  1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h100, 1'b0, 1'b0, 8, 5};

      rst = 1'b0;
      PCF = '0; PCE = '0; targetE = '0; updateE = 1'b0; isJumpE = 1'b0; takenE = 1'b0;
      predTakenE = 1'b0; predTargetE = '0; g_predTakenE = 1'b0; g_predTargetE = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 17; i++) begin
         PCF = vecs[i].pcf; updateE = vecs[i].upd; PCE = vecs[i].pce;
         takenE = vecs[i].tkn; targetE = vecs[i].tgt; isJumpE = 1'b0;
         predTakenE = vecs[i].ptk; predTargetE = vecs[i].ptg;
         g_predTakenE = vecs[i].ptk; g_predTargetE = vecs[i].ptg;
         @(negedge clk);
         chk($sformatf("v%0d_PCBPUSrc", i), W'(PCBPUSrc), W'(vecs[i].src));
         chk($sformatf("v%0d_PCBPU", i), PCBPU, vecs[i].pc);
         chk($sformatf("v%0d_predTakenF", i), W'(predTakenF), W'(vecs[i].ptf));
         chk($sformatf("v%0d_flushBranch", i), W'(flushBranch), W'(vecs[i].fl));
         chk($sformatf("v%0d_branchCount", i), W'(branchCount), W'(vecs[i].bc));
         chk($sformatf("v%0d_mispredCount", i), W'(mispredCount), W'(vecs[i].mc));
         @(posedge clk);
         #1;
      end

      // JAL trained once, then must keep predicting its target with no flush.
      PCF = 32'h100; updateE = 1'b1; isJumpE = 1'b1; PCE = 32'h100; takenE = 1'b1;
      targetE = 32'h200; predTakenE = 1'b0; predTargetE = 32'h0;
      @(negedge clk);
      chk("jal_train_flush", W'(flushBranch), 32'h1);
      chk("jal_train_PCBPU", PCBPU, 32'h200);
      @(posedge clk);
      #1;
      for (int i = 0; i < 10; i++) begin
         updateE = 1'b0;
         #1;
         p = predTakenF;
         t = PCBPU;
         chk($sformatf("jal%0d_predTakenF", i), W'(p), 32'h1);
         chk($sformatf("jal%0d_PCBPU", i), t, 32'h200);
         predTakenE = p; predTargetE = t; updateE = 1'b1;
         #1;
         chk($sformatf("jal%0d_flush", i), W'(flushBranch), 32'h0);
         @(posedge clk);
         #1;
      end
      updateE = 1'b0; isJumpE = 1'b0;
      @(negedge clk);
      chk("jal_branchCount", W'(branchCount), 32'd19);
      chk("jal_mispredCount", W'(mispredCount), 32'd6);

      // Reset asserted mid-cycle while a mispredicting update is presented.
      @(posedge clk);
      #1;
      PCF = 32'h100; updateE = 1'b1; PCE = 32'h100; takenE = 1'b0;
      predTakenE = 1'b1; predTargetE = 32'h200;
      #1;
      chk("pre_rst_flush", W'(flushBranch), 32'h1);
      rst = 1'b0;
      #1;
      chk("rst_PCBPUSrc", W'(PCBPUSrc), 32'h0);
      chk("rst_flush", W'(flushBranch), 32'h0);
      chk("rst_predTakenF", W'(predTakenF), 32'h0);
      chk("rst_PCBPU", PCBPU, 32'h0);
      chk("rst_branchCount", W'(branchCount), 32'h0);
      chk("rst_mispredCount", W'(mispredCount), 32'h0);
      @(posedge clk);
      #1;
      chk("rst_hold_flush", W'(flushBranch), 32'h0);
      @(negedge clk);
      rst = 1'b1; updateE = 1'b0;
      #1;
      chk("post_rst_100_pred", W'(predTakenF), 32'h0);
      chk("post_rst_100_src", W'(PCBPUSrc), 32'h0);
      PCF = 32'h84;
      #1;
      chk("post_rst_84_pred", W'(predTakenF), 32'h0);
      PCF = 32'h40;
      #1;
      chk("post_rst_40_pred", W'(predTakenF), 32'h0);
      chk("post_rst_branchCount", W'(branchCount), 32'h0);

      // Alternating T/N branch at 0x80 on the bimodal and gshare instances.
      bim_mis = 0; g_mis = 0; g_late = 0;
      @(posedge clk);
      #1;
      for (int k = 0; k < 20; k++) begin
         tk = ((k % 2) == 0);
         PCF = 32'h80; PCE = 32'h80; takenE = tk; targetE = 32'h90;
         isJumpE = 1'b0; updateE = 1'b0;
         #1;
         predTakenE = predTakenF; predTargetE = PCBPU;
         g_predTakenE = g_predTakenF; g_predTargetE = g_PCBPU;
         updateE = 1'b1;
         #1;
         exp_b = (tk != predTakenE) || (tk && (predTargetE != 32'h90));
         exp_g = (tk != g_predTakenE) || (tk && (g_predTargetE != 32'h90));
         chk($sformatf("alt%0d_bimodal_flush", k), W'(flushBranch), W'(exp_b));
         chk($sformatf("alt%0d_gshare_flush", k), W'(g_flushBranch), W'(exp_g));
         if (flushBranch) bim_mis++;
         if (g_flushBranch) g_mis++;
         if (g_flushBranch && (k >= 8)) g_late++;
         @(posedge clk);
         #1;
      end
      updateE = 1'b0;
      @(negedge clk);
      chk("gshare_late_mispredicts", W'(g_late), 32'h0);
      chk("gshare_total_mispredicts", W'(g_mis), 32'd2);
      chk("gshare_mispredCount", W'(g_mispredCount), 32'd2);
      chk("gshare_branchCount_wrap", W'(g_branchCount), 32'd4);
      chk("bimodal_half_mispredict", W'(bim_mis * 2 >= 20), 32'h1);
      chk("bimodal_mispredCount", W'(mispredCount), 32'd20);
      chk("bimodal_branchCount", W'(branchCount), 32'd20);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised dynamic branch predictor for the 5-stage pipeline: a direct-mapped branch target buffer (BTB) plus a pattern history table (PHT) of saturating counters, optionally gshare-indexed by a global history register. It replaces the static fetch-side predictor.
- Fetch side: predicts next PC from `PCF` in the same cycle.
- Execute side: resolves branches/jumps, trains the tables, raises the redirect/flush on mispredict.
- Also keeps branch and mispredict statistics counters.

## Interface
- `WIDTH`, 32: address/data width.
- `ENTRIES`, 16: BTB and PHT depth; power of two, ≥2. `IDX` = log2(`ENTRIES`).
- `CTR_BITS`, 2: PHT counter width, 1..4.
- `GHR_BITS`, 0: global history length; 0 = bimodal, 1..`IDX` = gshare.
- `STAT_BITS`, 16: statistics counter width.

Ports:
- `clk` in 1: clock; all state on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `PCF` in `WIDTH`: fetch PC.
- `updateE` in 1: execute-stage instruction is a branch or jump (`BranchE|JumpE`); qualifies all E inputs.
- `isJumpE` in 1: resolved instruction is JAL/JALR (unconditional).
- `PCE` in `WIDTH`: PC of resolved instruction.
- `takenE` in 1: actual outcome (1 for jumps).
- `targetE` in `WIDTH`: actual target (PC+imm, or ALU result for JALR).
- `predTakenE` in 1: prediction made at fetch, piped F→E.
- `predTargetE` in `WIDTH`: predicted target, piped F→E.
- `PCBPU` out `WIDTH`: next-PC override.
- `PCBPUSrc` out 1: select `PCBPU` over sequential PC.
- `predTakenF` out 1: fetch prediction, to be piped.
- `flushBranch` out 1: mispredict; flush F/D and D/E.
- `branchCount` out `STAT_BITS`: resolved instructions.
- `mispredCount` out `STAT_BITS`: mispredicts.

## Operation
- Index and tag:
  - BTB index `bi = PCF[IDX+1:2]`; tag = `PCF[WIDTH-1:IDX+2]`.
  - PHT index `pi = bi XOR {0, GHR}` (GHR zero-extended to `IDX`); `pi = bi` when `GHR_BITS=0`. Same formulas on `PCE` for update.
- BTB entry: `valid`, `tag`, `target`, `jump`. PHT entry: `CTR_BITS` counter.
- Fetch (combinational):
  - `hit` = `valid & tag match`.
  - `predTakenF` = `hit & (jump | counter MSB)`.
  - `PCBPU` = `target`.
- Mispredict (combinational from E inputs):
  - `mis` = `updateE & (takenE != predTakenE | (takenE & targetE != predTargetE))`.
- Output mux:
  - If `mis`: `PCBPUSrc=1`, `flushBranch=1`; `PCBPU` = `targetE` if `takenE`, else `PCE+4`. This overrides the fetch prediction.
  - Else: `PCBPUSrc=predTakenF`, `flushBranch=0`.
- Training on a clock edge with `updateE`:
  - Counter: `takenE` increments, otherwise decrements, saturating at `2^CTR_BITS-1` / 0. For `isJumpE`, the counter is set to max.
  - BTB: if `takenE`, write `valid=1`, tag, `targetE`, `jump=isJumpE` (allocate or refresh). A not-taken miss does not allocate.
  - A newly allocated entry's counter is set to weakly taken, `2^(CTR_BITS-1)`, instead of incrementing.
  - GHR: shifts in `takenE` at LSB, only when `isJumpE=0`. Updates are non-speculative.
  - Stats: `branchCount` +1; `mispredCount` +1 if `mis`. Both wrap modulo `2^STAT_BITS`.
- Reset (`rst=0`, asynchronous):
  - All `valid`=0.
  - Counters = weakly not-taken, `2^(CTR_BITS-1)-1`.
  - GHR=0, stats=0.
  - While reset is asserted, `PCBPUSrc`, `flushBranch` and `predTakenF` are forced 0; `PCBPU`=0.

## Timing
- Lookup: 0-cycle latency, same cycle as `PCF`.
- Redirect on mispredict:
  - Same cycle as the instruction is in E.
  - The pipeline's next `PCF` is the corrected PC.
  - Penalty is 2 cycles.
- Table writes take effect on the edge after `updateE`.
- Read-during-write, same index: fetch sees the old entry. No bypass.
- `updateE` while the pipeline stalls: training still occurs exactly once, because the top zeroes `updateE` on D/E flush bubbles.
- Reset mid-operation clears all state immediately. The first cycle after release predicts not-taken everywhere.
- `STAT_BITS` counters wrap silently: `2^STAT_BITS-1`+1 → 0.

## Test plan
- Reset, then `PCF`=0x40 → `predTakenF`=0, `PCBPUSrc`=0; both stat counters 0.
- Branch at 0x40, target 0x20, resolved taken with `predTakenE`=0:
  - Same cycle: `flushBranch`=1, `PCBPU`=0x20.
  - Next cycle, `PCF`=0x40 → `predTakenF`=1, `PCBPU`=0x20.
  - `mispredCount`=1.
- Same branch resolved not-taken 2× with `CTR_BITS`=2:
  - Counter 2→1→0; after the first update fetch predicts not-taken.
  - Predicted-taken, not-taken resolution redirects to 0x44.
- JAL at 0x100 → 0x200 trained once; then 10 not-taken-free fetches of 0x100 all predict 0x200, with no further flushes.
- `GHR_BITS`=2, alternating T/N branch:
  - Mispredicts stop after warm-up.
  - With `GHR_BITS`=0, the same pattern mispredicts ≥50%.
- Assert `rst`=0 mid-stream with `updateE`=1 → outputs 0 immediately; no table write; tables are empty after release.
